// File: rtl/food_spawn_rng.sv
// Food position generator: LFSR draws grid-aligned, in-bounds coordinates
// that avoid the snake head, then emits them as an X beat followed by a Y beat.
module food_spawn_rng #(
  parameter logic [8:0]  LFSR_SEED  = 9'h1A5,
  parameter int unsigned GRID_LOG2  = 4,
  parameter logic [8:0]  X_MIN      = 9'd16,
  parameter logic [8:0]  X_MAX      = 9'd496,
  parameter logic [8:0]  Y_MIN      = 9'd16,
  parameter logic [8:0]  Y_MAX      = 9'd464,
  parameter logic [5:0]  MAX_TRIES  = 6'd63,
  parameter logic [8:0]  FALLBACK_X = 9'd304,
  parameter logic [8:0]  FALLBACK_Y = 9'd240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eaten,
  input  logic [9:0] head_x,
  input  logic [9:0] head_y,
  output logic [8:0] rand_num,
  output logic       rand_drive,
  output logic       busy
);

  localparam logic [8:0] SEED_EFF  = (LFSR_SEED == 9'h000) ? 9'h001 : LFSR_SEED;
  localparam logic [8:0] GRID_MASK = ~((9'd1 << GRID_LOG2) - 9'd1);

  typedef enum logic [2:0] {
    IDLE, GEN_X, GEN_Y, CHECK, EMIT_X, EMIT_Y
  } state_t;

  state_t     state, state_nx;
  logic [8:0] lfsr, lfsr_nx;
  logic [5:0] tries, tries_nx, tries_inc;
  logic [8:0] x_reg, x_nx;
  logic [8:0] y_reg, y_nx;
  logic [8:0] rn_nx;
  logic       rd_nx;
  logic       busy_nx;
  logic [8:0] cand;
  logic       reject;

  always_comb begin
    lfsr_nx   = (lfsr == 9'h000) ? 9'h001 : {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    cand      = lfsr & GRID_MASK;
    tries_inc = tries + 6'd1;
    state_nx  = state;
    tries_nx  = tries;
    x_nx      = x_reg;
    y_nx      = y_reg;
    rn_nx     = rand_num;
    rd_nx     = 1'b0;
    reject    = 1'b0;

    case (state)
      IDLE: begin
        if (eaten) begin
          tries_nx = '0;
          state_nx = GEN_X;
        end
      end
      GEN_X: begin
        if (cand >= X_MIN && cand <= X_MAX) begin
          x_nx     = cand;
          state_nx = GEN_Y;
        end else begin
          reject = 1'b1;
        end
      end
      GEN_Y: begin
        if (cand >= Y_MIN && cand <= Y_MAX) begin
          y_nx     = cand;
          state_nx = CHECK;
        end else begin
          reject = 1'b1;
        end
      end
      CHECK: begin
        if ({1'b0, x_reg} == head_x && {1'b0, y_reg} == head_y) begin
          reject   = 1'b1;
          state_nx = GEN_X;
        end else begin
          state_nx = EMIT_X;
        end
      end
      EMIT_X: begin
        rd_nx    = 1'b1;
        rn_nx    = x_reg;
        state_nx = EMIT_Y;
      end
      EMIT_Y: begin
        rn_nx    = y_reg;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Exhausted retries override whatever the current state decided.
    if (reject) begin
      tries_nx = tries_inc;
      if (tries_inc == MAX_TRIES) begin
        x_nx     = FALLBACK_X;
        y_nx     = FALLBACK_Y;
        state_nx = EMIT_X;
      end
    end

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= SEED_EFF;
      tries      <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      rand_num   <= '0;
      rand_drive <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      lfsr       <= lfsr_nx;
      tries      <= tries_nx;
      x_reg      <= x_nx;
      y_reg      <= y_nx;
      rand_num   <= rn_nx;
      rand_drive <= rd_nx;
      busy       <= busy_nx;
    end
  end

endmodule
